// File: rtl/param_counter.sv
// Parametrised up/down counter with modulo limit, synchronous clear/load and
// selectable terminal behaviour (wrap, saturate, one-shot). All outputs registered.
module param_counter #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_VAL   = (2 ** WIDTH) - 1,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             up_dn,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] out_data,
    output logic             tc,
    output logic             done
);

    typedef enum logic [1:0] {
        ModeWrap    = 2'b00,
        ModeSat     = 2'b01,
        ModeOneShot = 2'b10,
        ModeWrapAlt = 2'b11
    } mode_e;

    localparam logic [WIDTH-1:0] MaxV = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RstV = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] load_clamped;
    logic             at_term;

    assign load_clamped = (load_data > MaxV) ? MaxV : load_data;
    assign at_term      = up_dn ? (count_q == MaxV) : (count_q == '0);

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        done_d  = done_q;
        if (clear) begin
            count_d = RstV;
            done_d  = 1'b0;
        end else if (load) begin
            count_d = load_clamped;
            done_d  = 1'b0;
        end else if (en && !done_q) begin
            if (!at_term) begin
                count_d = up_dn ? count_q + 1'b1 : count_q - 1'b1;
            end else begin
                // Terminal step: explicit wrap keeps the count inside 0..MAX_VAL
                case (mode_e'(mode))
                    ModeSat: begin
                        tc_d = 1'b1;
                    end
                    ModeOneShot: begin
                        tc_d   = 1'b1;
                        done_d = 1'b1;
                    end
                    default: begin
                        count_d = up_dn ? '0 : MaxV;
                        tc_d    = 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= RstV;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            done_q  <= done_d;
        end
    end

    assign out_data = count_q;
    assign tc       = tc_q;
    assign done     = done_q;

endmodule

// File: tb/tb_param_counter.sv
// Directed bench for param_counter: default 8-bit instance plus a WIDTH=4,
// MAX_VAL=9, RESET_VAL=5 instance for non-power-of-two modulo behaviour.
module tb_param_counter;

    logic       clk = 1'b0;
    logic       reset;

    logic       a_en, a_clear, a_load, a_up_dn;
    logic [7:0] a_load_data;
    logic [1:0] a_mode;
    logic [7:0] a_out;
    logic       a_tc, a_done;

    logic       b_en, b_clear, b_load, b_up_dn;
    logic [3:0] b_load_data;
    logic [1:0] b_mode;
    logic [3:0] b_out;
    logic       b_tc, b_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    param_counter dut_a (
        .clk       (clk),
        .reset     (reset),
        .en        (a_en),
        .clear     (a_clear),
        .load      (a_load),
        .load_data (a_load_data),
        .up_dn     (a_up_dn),
        .mode      (a_mode),
        .out_data  (a_out),
        .tc        (a_tc),
        .done      (a_done)
    );

    param_counter #(
        .WIDTH     (4),
        .MAX_VAL   (9),
        .RESET_VAL (5)
    ) dut_b (
        .clk       (clk),
        .reset     (reset),
        .en        (b_en),
        .clear     (b_clear),
        .load      (b_load),
        .load_data (b_load_data),
        .up_dn     (b_up_dn),
        .mode      (b_mode),
        .out_data  (b_out),
        .tc        (b_tc),
        .done      (b_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input int o, input int t, input int d);
        check({tag, ".out"}, 32'(a_out), o);
        check({tag, ".tc"}, 32'(a_tc), t);
        check({tag, ".done"}, 32'(a_done), d);
    endtask

    task automatic chk_b(input string tag, input int o, input int t);
        check({tag, ".out"}, 32'(b_out), o);
        check({tag, ".tc"}, 32'(b_tc), t);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        a_en = 0; a_clear = 0; a_load = 0; a_up_dn = 1; a_load_data = 0; a_mode = 2'b00;
        b_en = 0; b_clear = 0; b_load = 0; b_up_dn = 0; b_load_data = 0; b_mode = 2'b00;
        #2;
        chk_a("rst_a", 0, 0, 0);
        check("rst_b.out", 32'(b_out), 5);
        @(negedge clk);
        reset = 1'b0;

        // Wrap up through 255 -> 0
        a_load = 1; a_load_data = 8'd255;
        tick; chk_a("w_load", 255, 0, 0);
        a_load = 0; a_en = 1;
        tick; chk_a("w_wrap", 0, 1, 0);
        tick; chk_a("w_1", 1, 0, 0);
        tick; chk_a("w_2", 2, 0, 0);

        // Saturate at 255, then reverse
        a_mode = 2'b01; a_load = 1; a_load_data = 8'd253;
        tick; chk_a("s_load", 253, 0, 0);
        a_load = 0;
        tick; chk_a("s_254", 254, 0, 0);
        tick; chk_a("s_255", 255, 0, 0);
        tick; chk_a("s_hold1", 255, 1, 0);
        tick; chk_a("s_hold2", 255, 1, 0);
        a_up_dn = 0;
        tick; chk_a("s_rev", 254, 0, 0);

        // One-shot
        a_mode = 2'b10; a_up_dn = 1; a_load = 1; a_load_data = 8'd250;
        tick; chk_a("o_load", 250, 0, 0);
        a_load = 0;
        repeat (5) tick;
        chk_a("o_255", 255, 0, 0);
        tick; chk_a("o_done", 255, 1, 1);
        tick; chk_a("o_stay", 255, 0, 1);
        a_up_dn = 0;
        tick; chk_a("o_dn_ign", 255, 0, 1);
        a_en = 0;
        tick; chk_a("o_en_off", 255, 0, 1);
        a_en = 1; a_mode = 2'b00;
        tick; chk_a("o_mode_chg", 255, 0, 1);
        a_load = 1; a_load_data = 8'd7;
        tick; chk_a("o_reload", 7, 0, 0);

        // Priority: clear > load > step
        a_up_dn = 1; a_load_data = 8'd100;
        tick; chk_a("p_load100", 100, 0, 0);
        a_clear = 1; a_load_data = 8'd50;
        tick; chk_a("p_clear", 0, 0, 0);
        a_clear = 0;
        tick; chk_a("p_load_en", 50, 0, 0);
        a_load = 0; a_en = 0;
        tick; chk_a("p_idle", 50, 0, 0);

        // Small instance: modulo 10 down, clamp, up wrap, clear to RESET_VAL
        b_load = 1; b_load_data = 4'd2;
        tick; chk_b("b_load", 2, 0);
        b_load = 0; b_en = 1;
        tick; chk_b("b_1", 1, 0);
        tick; chk_b("b_0", 0, 0);
        tick; chk_b("b_wrap9", 9, 1);
        tick; chk_b("b_8", 8, 0);
        b_load = 1; b_load_data = 4'd15;
        tick; chk_b("b_clamp", 9, 0);
        b_load = 0; b_up_dn = 1;
        tick; chk_b("b_up_wrap", 0, 1);
        b_clear = 1;
        tick; chk_b("b_clear", 5, 0);
        b_clear = 0; b_en = 0;

        // Asynchronous reset mid-count
        a_mode = 2'b00; a_en = 1; a_load = 1; a_load_data = 8'd35;
        tick;
        a_load = 0;
        tick; tick; chk_a("r_37", 37, 0, 0);
        #3 reset = 1'b1;
        #1 chk_a("r_async", 0, 0, 0);
        tick; chk_a("r_held", 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        #1 chk_a("r_release", 0, 0, 0);
        tick; chk_a("r_restart", 1, 0, 0);
        tick; chk_a("r_2", 2, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
